// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline boundary feeding the ALU.
// Decoded beats go through a 2-entry skid buffer (main + skid) with valid/ready
// handshakes on both sides. id_ready comes straight from a flop, so there is no
// combinational path from ex_ready. flush kills every held beat.
// Optional feature macro: FORWARD_EN. When it is defined, writeback results are
// forwarded into the operands at capture time. When it is undefined, the wb_*
// inputs are ignored.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_ImmExt,
  input  logic [CTRL_W-1:0] id_ALUCtrl,
  input  logic              id_ALUSrc,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_RegWrite,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   srcA,
  output logic [XLEN-1:0]   srcB_reg,
  output logic [XLEN-1:0]   srcB_ImmExt,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              ALUSrc,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_RegWrite,
  input  logic              wb_RegWrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_Result
);

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
    logic              alusrc;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } beat_t;

  beat_t main_q, skid_q, in_beat;
  logic  main_vld, skid_vld;
  logic  accept, pop;

  assign accept = id_valid & ~skid_vld;
  assign pop    = main_vld & ex_ready;

  // Build the incoming beat and apply optional writeback forwarding.
  always_comb begin
    in_beat          = '0;
    in_beat.a        = id_rs1_data;
    in_beat.b        = id_rs2_data;
    in_beat.imm      = id_ImmExt;
    in_beat.ctrl     = id_ALUCtrl;
    in_beat.alusrc   = id_ALUSrc;
    in_beat.rd       = id_rd;
    in_beat.regwrite = id_RegWrite;
`ifdef FORWARD_EN
    if (wb_RegWrite && (wb_rd != '0) && (wb_rd == id_rs1)) in_beat.a = wb_Result;
    if (wb_RegWrite && (wb_rd != '0) && (wb_rd == id_rs2)) in_beat.b = wb_Result;
`endif
  end

`ifndef FORWARD_EN
  // The writeback bus has no effect in this build.
  logic unused_wb;
  assign unused_wb = &{1'b0, wb_RegWrite, wb_rd, wb_Result, id_rs1, id_rs2};
`endif

  // Main/skid state. The skid only ever fills while main is full and stalled.
  // A refill from the skid takes priority over a new beat; the two cannot
  // collide because id_ready is low whenever the skid is occupied.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (pop && skid_vld) begin
      main_q   <= skid_q;
      main_vld <= 1'b1;
      skid_vld <= 1'b0;
    end else if (!main_vld || pop) begin
      main_vld <= accept;
      if (accept) main_q <= in_beat;
    end else if (accept) begin
      skid_q   <= in_beat;
      skid_vld <= 1'b1;
    end
  end

  assign id_ready    = ~skid_vld;
  assign ex_valid    = main_vld;
  assign srcA        = main_q.a;
  assign srcB_reg    = main_q.b;
  assign srcB_ImmExt = main_q.imm;
  assign ALUControl  = main_q.ctrl;
  assign ALUSrc      = main_q.alusrc;
  assign ex_rd       = main_q.rd;
  // A write to x0 never issues, and neither does a write from an invalid beat.
  assign ex_RegWrite = main_q.regwrite & main_vld & (main_q.rd != '0);

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of single-beat vectors plus
// hand sequences for reset, skid backpressure, flush and forwarding.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        nreset, flush, id_valid, id_ready, ex_valid, ex_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd, ex_rd, wb_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_ImmExt, srcA, srcB_reg, srcB_ImmExt, wb_Result;
  logic [2:0]  id_ALUCtrl, ALUControl;
  logic        id_ALUSrc, ALUSrc, id_RegWrite, ex_RegWrite, wb_RegWrite;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .nreset(nreset), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_ImmExt(id_ImmExt),
    .id_ALUCtrl(id_ALUCtrl), .id_ALUSrc(id_ALUSrc), .id_rd(id_rd), .id_RegWrite(id_RegWrite),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .srcA(srcA), .srcB_reg(srcB_reg), .srcB_ImmExt(srcB_ImmExt),
    .ALUControl(ALUControl), .ALUSrc(ALUSrc), .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_Result(wb_Result)
  );

  typedef struct {
    logic [31:0] rs1d, rs2d, imm;
    logic [2:0]  ctrl;
    logic        alusrc;
    logic [4:0]  rd;
    logic        rw;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs are changed 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] b);
    id_valid = 1'b1; id_rs1_data = a; id_rs2_data = b; id_ImmExt = a ^ 32'hFFFF;
    id_ALUCtrl = 3'b010; id_ALUSrc = 1'b0; id_rd = 5'd4; id_RegWrite = 1'b1;
    id_rs1 = 5'd1; id_rs2 = 5'd2;
  endtask

  initial begin
    vecs[0] = '{32'd5, 32'd3, 32'd0, 3'b000, 1'b0, 5'd3, 1'b1, 1'b1};
    vecs[1] = '{32'hDEADBEEF, 32'h0000_0001, 32'hFFFF_FFF0, 3'b001, 1'b1, 5'd0, 1'b1, 1'b0};
    vecs[2] = '{32'h1234_5678, 32'h8765_4321, 32'h0000_0010, 3'b111, 1'b0, 5'd31, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3'b101, 1'b1, 5'd17, 1'b1, 1'b1};
    vecs[4] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h7FFF_FFFF, 3'b011, 1'b0, 5'd0, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_00FF, 32'h0000_0100, 32'h0000_0abc, 3'b100, 1'b1, 5'd3, 1'b1, 1'b1};

    nreset = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3; id_RegWrite = 1'b1;
    id_rs1_data = 32'h55; id_rs2_data = 32'h66; id_ImmExt = 32'h77;
    id_ALUCtrl = 3'b110; id_ALUSrc = 1'b1; id_valid = 1'b1;
    wb_RegWrite = 1'b0; wb_rd = 5'd0; wb_Result = 32'h0;

    // Reset: the beat offered while nreset is low is never captured.
    tick(); tick();
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_srcA", srcA, 32'd0);
    chk("rst_ctrl", {29'd0, ALUControl}, 32'd0);
    chk("rst_ex_regwrite", {31'd0, ex_RegWrite}, 32'd0);
    id_valid = 1'b0; nreset = 1'b1;
    tick();
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
    chk("rst_idle_ex_valid", {31'd0, ex_valid}, 32'd0);

    // Table vectors, streamed back to back with ex_ready held high.
    for (int i = 0; i < 6; i++) begin
      id_valid = 1'b1; id_rs1_data = vecs[i].rs1d; id_rs2_data = vecs[i].rs2d;
      id_ImmExt = vecs[i].imm; id_ALUCtrl = vecs[i].ctrl; id_ALUSrc = vecs[i].alusrc;
      id_rd = vecs[i].rd; id_RegWrite = vecs[i].rw;
      tick();
      chk($sformatf("v%0d_ex_valid", i), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("v%0d_srcA", i), srcA, vecs[i].rs1d);
      chk($sformatf("v%0d_srcB_reg", i), srcB_reg, vecs[i].rs2d);
      chk($sformatf("v%0d_imm", i), srcB_ImmExt, vecs[i].imm);
      chk($sformatf("v%0d_ctrl", i), {28'd0, ALUSrc, ALUControl}, {28'd0, vecs[i].alusrc, vecs[i].ctrl});
      chk($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].rd});
      chk($sformatf("v%0d_regwrite", i), {31'd0, ex_RegWrite}, {31'd0, vecs[i].exp_rw});
      if (i == 0) chk("v0_alu_sum", srcA + srcB_reg, 32'd8);
    end
    id_valid = 1'b0;
    tick();
    chk("drain_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("drain_ex_regwrite", {31'd0, ex_RegWrite}, 32'd0);

    // Backpressure: beats A, B and C are offered while EX is stalled.
    ex_ready = 1'b0;
    offer(32'hA, 32'h1A); tick();
    chk("bp_A_main", srcA, 32'hA);
    chk("bp_A_ready", {31'd0, id_ready}, 32'd1);
    offer(32'hB, 32'h1B); tick();
    chk("bp_B_skid_ready", {31'd0, id_ready}, 32'd0);
    chk("bp_A_held", srcA, 32'hA);
    offer(32'hC, 32'h1C); tick();
    chk("bp_C_stalled_ready", {31'd0, id_ready}, 32'd0);
    chk("bp_A_still", srcA, 32'hA);
    chk("bp_valid", {31'd0, ex_valid}, 32'd1);
    ex_ready = 1'b1; tick();
    chk("bp_B_out", srcA, 32'hB);
    chk("bp_B_srcB", srcB_reg, 32'h1B);
    chk("bp_ready_back", {31'd0, id_ready}, 32'd1);
    tick();
    chk("bp_C_out", srcA, 32'hC);
    id_valid = 1'b0; tick();
    chk("bp_empty", {31'd0, ex_valid}, 32'd0);

    // Flush with both entries full; the beat offered alongside flush is lost.
    ex_ready = 1'b0;
    offer(32'hD0, 32'h0); tick();
    offer(32'hD1, 32'h0); tick();
    chk("fl_skid_full", {31'd0, id_ready}, 32'd0);
    id_valid = 1'b0; flush = 1'b1; tick();
    chk("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_id_ready", {31'd0, id_ready}, 32'd1);
    chk("fl_stale_srcA", srcA, 32'hD0);
    offer(32'hE0, 32'h0); tick();
    chk("fl_beat_dropped", {31'd0, ex_valid}, 32'd0);
    flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1; tick();
    chk("fl_still_empty", {31'd0, ex_valid}, 32'd0);

    // Writeback forwarding at capture.
    offer(32'h0, 32'h0); id_rs1 = 5'd7;
    wb_RegWrite = 1'b1; wb_rd = 5'd7; wb_Result = 32'h0400AB05;
    tick();
`ifdef FORWARD_EN
    chk("fwd_srcA", srcA, 32'h0400AB05);
`else
    chk("fwd_srcA", srcA, 32'h0);
`endif
    id_rs1_data = 32'h11; tick();
`ifdef FORWARD_EN
    chk("fwd_srcA_nz", srcA, 32'h0400AB05);
`else
    chk("fwd_srcA_nz", srcA, 32'h11);
`endif
    chk("fwd_srcB_untouched", srcB_reg, 32'h0);
    id_rs1 = 5'd0; id_rs1_data = 32'h0; wb_rd = 5'd0; tick();
    chk("fwd_x0_srcA", srcA, 32'h0);
    id_valid = 1'b0; wb_RegWrite = 1'b0; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
